// File: rtl/seg_pkg.sv
// seg_pkg: shared encodings for the six-digit seven-segment scanner.
// Game-state codes, active-low segment patterns and the digit count.
package seg_pkg;

    typedef enum logic [1:0] {
        GS_RESTART   = 2'b00,
        GS_PLAY      = 2'b01,
        GS_GAME_OVER = 2'b10
    } game_status_e;

    localparam int NUM_DIGITS = 6;

    // Active-low {dp, g, f, e, d, c, b, a}; dp is always off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Entry n is the pattern for decimal digit n.
    localparam logic [9:0][7:0] SEG_DIGITS = {
        8'h90,  // 9
        8'h80,  // 8
        8'hF8,  // 7
        8'h82,  // 6
        8'h92,  // 5
        8'h99,  // 4
        8'hB0,  // 3
        8'hA4,  // 2
        8'hF9,  // 1
        8'hC0   // 0
    };

endpackage

// File: rtl/seg_decode.sv
// seg_decode: BCD nibble to active-low seven-segment pattern.
// Nibbles above 9 render as a dash; the blank flag overrides everything.
import seg_pkg::*;

module seg_decode (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    // Pattern lookup with blank taking priority over invalid-digit dash.
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (nibble_i <= 4'd9) begin
            seg_o = SEG_DIGITS[nibble_i];
        end
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for a six-digit common-anode display.
// Digits 0-2 show the current score, 3-5 the best score, both taken from a
// per-frame snapshot. Optional game-over blink of the score digits is built
// only when SEG_SCAN_BLINK_EN is defined.
import seg_pkg::*;

module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] bcd_data,
    input  logic [11:0] bcd_data_best,
    input  logic [1:0]  game_status,
    output logic [7:0]  seg,
    output logic [5:0]  sel
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             lit_q, lit_d;
    logic [11:0]      snap_q, snap_d;
    logic [11:0]      snap_best_q, snap_best_d;
    logic [7:0]       seg_q, seg_d;
    logic [5:0]       sel_q, sel_d;
    logic             tick;
    logic             blink_on_d;

    logic [11:0]      grp;
    logic [1:0]       pos;
    logic [3:0]       nib;
    logic             blank;
    logic [7:0]       seg_pat;

    assign tick = (div_cnt_q == DIV_MAX);

    // Divider, digit index and frame snapshot. The first tick after reset
    // starts the display on digit 0 (rather than advancing) so that a
    // reset always restarts the scan from the score units.
    always_comb begin
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        idx_d       = idx_q;
        lit_d       = lit_q | tick;
        snap_d      = snap_q;
        snap_best_d = snap_best_q;
        if (tick) begin
            if (!lit_q || idx_q == LAST_IDX) begin
                idx_d       = '0;
                snap_d      = bcd_data;
                snap_best_d = bcd_data_best;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FRM_W = $clog2(BLINK_FRAMES + 1);

    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             blink_on_q;
    logic             game_over;
    logic             frame_wrap;

    assign game_over  = (game_status == GS_GAME_OVER);
    assign frame_wrap = tick && lit_q && (idx_q == LAST_IDX);

    // Blink phase: toggles every BLINK_FRAMES frame wraps in game-over,
    // snaps back to lit as soon as the game leaves that state.
    always_comb begin
        frm_cnt_d  = frm_cnt_q;
        blink_on_d = blink_on_q;
        if (!game_over) begin
            frm_cnt_d  = '0;
            blink_on_d = 1'b1;
        end else if (frame_wrap) begin
            if (frm_cnt_q == FRM_W'(BLINK_FRAMES - 1)) begin
                frm_cnt_d  = '0;
                blink_on_d = !blink_on_q;
            end else begin
                frm_cnt_d = frm_cnt_q + 1'b1;
            end
        end
    end

    // Blink state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt_q  <= '0;
            blink_on_q <= 1'b1;
        end else begin
            frm_cnt_q  <= frm_cnt_d;
            blink_on_q <= blink_on_d;
        end
    end
`else
    // Port kept for a stable interface; nothing consumes it in this build.
    logic [1:0]  unused_game_status;
    localparam int unused_blink_frames = BLINK_FRAMES;
    assign unused_game_status = game_status;
    assign blink_on_d         = 1'b1;
`endif

    // Pick the nibble for the digit that will be lit after this edge and
    // work out leading-zero / blink blanking for it.
    always_comb begin
        grp   = (idx_d >= 3'd3) ? snap_best_d : snap_d;
        pos   = (idx_d >= 3'd3) ? 2'(idx_d - 3'd3) : idx_d[1:0];
        nib   = grp[3:0];
        blank = 1'b0;
        case (pos)
            2'd0: begin
                nib   = grp[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = grp[7:4];
                blank = (grp[11:8] == 4'd0) && (grp[7:4] == 4'd0);
            end
            default: begin
                nib   = grp[11:8];
                blank = (grp[11:8] == 4'd0);
            end
        endcase
        if (!blink_on_d && idx_d < 3'd3) begin
            blank = 1'b1;
        end
    end

    seg_decode u_decode (
        .nibble_i (nib),
        .blank_i  (blank),
        .seg_o    (seg_pat)
    );

    // Output next-state: dark until the display has started, then exactly
    // one select low.
    always_comb begin
        sel_d = 6'h3F;
        seg_d = SEG_BLANK;
        if (lit_d) begin
            sel_d = ~(6'b000001 << idx_d);
            seg_d = seg_pat;
        end
    end

    // Scan state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q   <= '0;
            idx_q       <= '0;
            lit_q       <= 1'b0;
            snap_q      <= '0;
            snap_best_q <= '0;
            sel_q       <= 6'h3F;
            seg_q       <= SEG_BLANK;
        end else begin
            div_cnt_q   <= div_cnt_d;
            idx_q       <= idx_d;
            lit_q       <= lit_d;
            snap_q      <= snap_d;
            snap_best_q <= snap_best_d;
            sel_q       <= sel_d;
            seg_q       <= seg_d;
        end
    end

    assign seg = seg_q;
    assign sel = sel_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed checks of the seg_scan display driver with SCAN_DIV=4.
// Blink checks are built when SEG_SCAN_BLINK_EN is defined.
module tb_seg_scan;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_data;
    logic [11:0] bcd_data_best;
    logic [1:0]  game_status;
    logic [7:0]  seg;
    logic [5:0]  sel;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_sel [0:6];
    logic [7:0] exp_seg [0:6];

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .bcd_data      (bcd_data),
        .bcd_data_best (bcd_data_best),
        .game_status   (game_status),
        .seg           (seg),
        .sel           (sel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dig(input string tag, input logic [5:0] es, input logic [7:0] eg);
        chk({tag, "_sel"}, 32'(sel), 32'(es));
        chk({tag, "_seg"}, 32'(seg), 32'(eg));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_sel = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h3E};
        exp_seg = '{8'hC0, 8'hC0, 8'hF9, 8'hF8, 8'hFF, 8'hFF, 8'hC0};

        rst           = 1'b1;
        bcd_data      = 12'h100;
        bcd_data_best = 12'h007;
        game_status   = 2'b01;
        adv(2);
        dig("reset", 6'h3F, 8'hFF);

        // Release; dark for the first SCAN_DIV-1 edges.
        rst = 1'b0;
        adv(3);
        dig("dark", 6'h3F, 8'hFF);
        adv(1);

        // Score 100 / best 007: full frame walk plus wrap, each digit held 4 cycles.
        for (int k = 0; k < 7; k++) begin
            dig($sformatf("walk%0d", k), exp_sel[k], exp_seg[k]);
            if (k < 6) begin
                adv(3);
                dig($sformatf("hold%0d", k), exp_sel[k], exp_seg[k]);
                adv(1);
            end
        end

        // Snapshot isolation: 012 captured at the next wrap, later changes wait a frame.
        bcd_data = 12'h012;
        adv(24);
        dig("snap_u2", 6'h3E, 8'hA4);
        adv(1);
        bcd_data      = 12'h013;
        bcd_data_best = 12'h999;
        adv(1);
        dig("tear_u2", 6'h3E, 8'hA4);
        adv(2);
        dig("tear_t1", 6'h3D, 8'hF9);
        adv(4);
        dig("tear_h", 6'h3B, 8'hFF);
        adv(4);
        dig("tear_b7", 6'h37, 8'hF8);
        adv(12);
        dig("new_u3", 6'h3E, 8'hB0);
        adv(12);
        dig("new_bu9", 6'h37, 8'h90);
        adv(4);
        dig("new_bt9", 6'h2F, 8'h90);
        adv(4);
        dig("new_bh9", 6'h1F, 8'h90);

        // Invalid nibbles: dash, and never counted as zero for blanking.
        bcd_data      = 12'h0A5;
        bcd_data_best = 12'hA05;
        adv(4);
        dig("inv_u5", 6'h3E, 8'h92);
        adv(4);
        dig("inv_tdash", 6'h3D, 8'hBF);
        adv(4);
        dig("inv_hblank", 6'h3B, 8'hFF);
        adv(4);
        dig("inv_bu5", 6'h37, 8'h92);
        adv(4);
        dig("inv_bt0", 6'h2F, 8'hC0);
        adv(4);
        dig("inv_bhdash", 6'h1F, 8'hBF);

        // Asynchronous reset mid-digit, then restart from digit 0 with score 0.
        adv(1);
        rst = 1'b1;
        #1;
        dig("async_rst", 6'h3F, 8'hFF);
        bcd_data = 12'h000;
        adv(2);
        rst = 1'b0;
        adv(3);
        dig("dark2", 6'h3F, 8'hFF);
        adv(1);
        dig("zero_u", 6'h3E, 8'hC0);
        adv(4);
        dig("zero_t", 6'h3D, 8'hFF);
        adv(4);
        dig("zero_h", 6'h3B, 8'hFF);

        game_status = 2'b10;
`ifdef SEG_SCAN_BLINK_EN
        adv(16);
        dig("blink_off", 6'h3E, 8'hFF);
        adv(12);
        dig("blink_best", 6'h37, 8'h92);
        adv(12);
        dig("blink_on", 6'h3E, 8'hC0);
        adv(24);
        dig("blink_off2", 6'h3E, 8'hFF);
        adv(1);
        game_status = 2'b01;
        adv(23);
        dig("play_lit", 6'h3E, 8'hC0);
`else
        adv(16);
        dig("noblink", 6'h3E, 8'hC0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
